// File: rtl/spi_flash_pkg.sv
// -----------------------------------------------------------------------------
// spi_flash_pkg
// Shared constants and types for the SPI NOR flash command sequencer.
//   - flash opcodes and the 2-bit cmd_op encodings
//   - FSM state enum
//   - READ opcode / header length, selected by SPI_FLASH_FAST_READ_EN
//     (defined: 0x0B plus one dummy byte, header 5; undefined: 0x03, header 4)
//   - eff_len(): maps a requested length onto the 1..MAX_LEN range
// -----------------------------------------------------------------------------
package spi_flash_pkg;

   // Flash opcodes
   localparam logic [7:0] OPC_READ      = 8'h03;
   localparam logic [7:0] OPC_FAST_READ = 8'h0B;
   localparam logic [7:0] OPC_RDID      = 8'h9F;
   localparam logic [7:0] OPC_RDSR      = 8'h05;
   localparam logic [7:0] OPC_WREN      = 8'h06;

   // cmd_op encodings
   localparam logic [1:0] OP_READ = 2'd0;
   localparam logic [1:0] OP_RDID = 2'd1;
   localparam logic [1:0] OP_RDSR = 2'd2;
   localparam logic [1:0] OP_WREN = 2'd3;

   localparam int MAX_LEN = 256;
   // Byte index width: max frame is 5 header + 256 data + 1 trailing load.
   localparam int IDX_W   = 9;

`ifdef SPI_FLASH_FAST_READ_EN
   localparam logic [7:0] READ_OPC     = OPC_FAST_READ;
   localparam logic [3:0] READ_HDR_LEN = 4'd5;
`else
   localparam logic [7:0] READ_OPC     = OPC_READ;
   localparam logic [3:0] READ_HDR_LEN = 4'd4;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_XFER,
      ST_STOP,
      ST_FLUSH,
      ST_GAP
   } state_e;

   // Zero-length requests read one byte; anything above MAX_LEN is clamped so
   // the index counters can never run past the largest legal frame.
   function automatic logic [IDX_W-1:0] eff_len(input logic [IDX_W-1:0] len);
      if (len == '0)
         return IDX_W'(1);
      else if (len > IDX_W'(MAX_LEN))
         return IDX_W'(MAX_LEN);
      else
         return len;
   endfunction

endpackage

// File: rtl/spi_flash_hdr.sv
// -----------------------------------------------------------------------------
// spi_flash_hdr
// Combinational header-byte mux. Given the command, its address and a 1-based
// byte number within the frame, returns the byte to transmit. Every byte past
// the header (dummy and data positions) is 0x00. Also reports the header length.
// Ports:
//   op_i      cmd_op encoding
//   addr_i    24-bit flash address (used by READ only)
//   idx_i     1-based frame byte number
//   byte_o    transmit byte for that position
//   hdr_len_o number of header bytes for op_i
// Honors SPI_FLASH_FAST_READ_EN through the package READ constants.
// -----------------------------------------------------------------------------
module spi_flash_hdr
   import spi_flash_pkg::*;
(
   input  logic [1:0]       op_i,
   input  logic [23:0]      addr_i,
   input  logic [IDX_W-1:0] idx_i,
   output logic [7:0]       byte_o,
   output logic [3:0]       hdr_len_o
);

   logic is_read;

   assign is_read = (op_i == OP_READ);

   always_comb begin
      hdr_len_o = is_read ? READ_HDR_LEN : 4'd1;
      byte_o    = 8'h00;
      case (idx_i)
         IDX_W'(1): begin
            case (op_i)
               OP_READ: byte_o = READ_OPC;
               OP_RDID: byte_o = OPC_RDID;
               OP_RDSR: byte_o = OPC_RDSR;
               default: byte_o = OPC_WREN;
            endcase
         end
         IDX_W'(2): if (is_read) byte_o = addr_i[23:16];
         IDX_W'(3): if (is_read) byte_o = addr_i[15:8];
         IDX_W'(4): if (is_read) byte_o = addr_i[7:0];
         // fast-read dummy byte and all data bytes transmit 0x00
         default:   byte_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/spi_flash_ctrl.sv
// -----------------------------------------------------------------------------
// spi_flash_ctrl
// Command sequencer upstream of the SPI byte engine. Accepts one flash command
// at a time, frames it with spi_en, feeds header/filler bytes on each engine
// load and returns data bytes as a one-cycle rd_valid stream.
// Optional feature macro: SPI_FLASH_FAST_READ_EN (READ uses 0x0B + dummy byte).
// Parameters:
//   CS_GAP        minimum cycles spi_en stays low between frames (default 4)
// Ports:
//   sclk_i        system / byte-engine clock
//   rst_n_i       synchronous active-low reset
//   cmd_valid_i   request present
//   cmd_ready_o   high only while idle; accept on cmd_valid_i & cmd_ready_o
//   cmd_op_i      0=READ 1=READ_ID 2=READ_STATUS 3=WRITE_EN
//   cmd_addr_i    flash byte address (READ)
//   cmd_len_i     data bytes to read, 0 treated as 1 (ignored for WRITE_EN)
//   rd_data_o     received data byte
//   rd_valid_o    one-cycle strobe per data byte
//   done_o        one-cycle strobe at frame completion
//   busy_o        high from acceptance until back in idle
//   spi_en_o      byte-engine frame enable
//   spi_txbyte_o  byte offered to the engine
//   spi_flag_i    engine flag: rise = tx byte loaded, fall = rx byte published
//   spi_rxbyte_i  engine received byte
// -----------------------------------------------------------------------------
module spi_flash_ctrl
   import spi_flash_pkg::*;
#(
   parameter int CS_GAP = 4
) (
   input  logic        sclk_i,
   input  logic        rst_n_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [1:0]  cmd_op_i,
   input  logic [23:0] cmd_addr_i,
   input  logic [8:0]  cmd_len_i,
   output logic [7:0]  rd_data_o,
   output logic        rd_valid_o,
   output logic        done_o,
   output logic        busy_o,
   output logic        spi_en_o,
   output logic [7:0]  spi_txbyte_o,
   input  logic        spi_flag_i,
   input  logic [7:0]  spi_rxbyte_i
);

   localparam int GAP_W = $clog2(CS_GAP + 2) + 1;

   state_e           state_q;
   logic [1:0]       op_q;
   logic [23:0]      addr_q;
   logic [IDX_W-1:0] total_q;    // T: header + data bytes
   logic [3:0]       hdr_len_q;
   logic [IDX_W-1:0] tx_idx_q;   // load events seen this frame
   logic [IDX_W-1:0] rx_idx_q;   // rx bytes consumed this frame
   logic [GAP_W-1:0] wait_q;     // FLUSH / GAP cycle counter
   logic             flag_q;
   logic             cmd_ready_q;
   logic             busy_q;
   logic             spi_en_q;
   logic [7:0]       spi_txbyte_q;
   logic [7:0]       rd_data_q;
   logic             rd_valid_q;
   logic             done_q;

   logic             load_ev;
   logic             done_ev;
   logic             in_idle;
   logic             accept;
   logic [1:0]       hdr_op;
   logic [23:0]      hdr_addr;
   logic [IDX_W-1:0] hdr_idx;
   logic [7:0]       hdr_byte;
   logic [3:0]       hdr_len;
   logic [IDX_W-1:0] total_d;
   logic [IDX_W-1:0] rx_next;
   logic [IDX_W-1:0] hdr_len_ext;

   assign load_ev = spi_flag_i & ~flag_q;
   assign done_ev = ~spi_flag_i & flag_q;
   assign in_idle = (state_q == ST_IDLE);
   assign accept  = in_idle & cmd_valid_i & cmd_ready_q;

   // While idle the mux looks at the live request so byte 1 can be presented
   // on the acceptance edge; afterwards it follows the latched command and
   // yields the byte after the one just loaded.
   assign hdr_op   = in_idle ? cmd_op_i   : op_q;
   assign hdr_addr = in_idle ? cmd_addr_i : addr_q;
   assign hdr_idx  = in_idle ? IDX_W'(1)  : tx_idx_q + IDX_W'(2);

   assign total_d = (cmd_op_i == OP_WREN) ? IDX_W'(1)
                                          : {(IDX_W-4)'(0), hdr_len} + eff_len(cmd_len_i);
   assign rx_next     = rx_idx_q + IDX_W'(1);
   assign hdr_len_ext = {(IDX_W-4)'(0), hdr_len_q};

   spi_flash_hdr u_hdr (
      .op_i      (hdr_op),
      .addr_i    (hdr_addr),
      .idx_i     (hdr_idx),
      .byte_o    (hdr_byte),
      .hdr_len_o (hdr_len)
   );

   always_ff @(posedge sclk_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_READ;
         addr_q       <= '0;
         total_q      <= '0;
         hdr_len_q    <= '0;
         tx_idx_q     <= '0;
         rx_idx_q     <= '0;
         wait_q       <= '0;
         flag_q       <= 1'b0;
         cmd_ready_q  <= 1'b0;
         busy_q       <= 1'b0;
         spi_en_q     <= 1'b0;
         spi_txbyte_q <= 8'h00;
         rd_data_q    <= 8'h00;
         rd_valid_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         flag_q     <= spi_flag_i;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q         <= cmd_op_i;
                  addr_q       <= cmd_addr_i;
                  total_q      <= total_d;
                  hdr_len_q    <= hdr_len;
                  tx_idx_q     <= '0;
                  rx_idx_q     <= '0;
                  spi_en_q     <= 1'b1;
                  spi_txbyte_q <= hdr_byte;
                  busy_q       <= 1'b1;
                  cmd_ready_q  <= 1'b0;
                  state_q      <= ST_START;
               end else begin
                  cmd_ready_q  <= 1'b1;
               end
            end

            // START shares the event handling so an engine that loads on its
            // very first cycle is not missed.
            ST_START, ST_XFER: begin
               state_q <= ST_XFER;
               // Byte T arrives after the frame closes and is taken in FLUSH.
               if (done_ev && (rx_next < total_q)) begin
                  rx_idx_q <= rx_next;
                  if (rx_next > hdr_len_ext) begin
                     rd_data_q  <= spi_rxbyte_i;
                     rd_valid_q <= 1'b1;
                  end
               end
               if (load_ev) begin
                  tx_idx_q     <= tx_idx_q + IDX_W'(1);
                  spi_txbyte_q <= hdr_byte;
                  // Load T+1 is the trailing filler that clocks out byte T.
                  if (tx_idx_q == total_q) begin
                     spi_en_q     <= 1'b0;
                     spi_txbyte_q <= 8'h00;
                     state_q      <= ST_STOP;
                  end
               end
            end

            ST_STOP: begin
               wait_q  <= '0;
               state_q <= ST_FLUSH;
            end

            // Give the engine two cycles to publish the final rx byte.
            ST_FLUSH: begin
               if (wait_q == GAP_W'(1)) begin
                  if (total_q > hdr_len_ext) begin
                     rd_data_q  <= spi_rxbyte_i;
                     rd_valid_q <= 1'b1;
                  end
                  done_q  <= 1'b1;
                  wait_q  <= '0;
                  state_q <= ST_GAP;
               end else begin
                  wait_q  <= wait_q + GAP_W'(1);
               end
            end

            // Counting to CS_GAP (not CS_GAP-1) places cmd_ready CS_GAP+1
            // cycles after done.
            ST_GAP: begin
               if (wait_q == GAP_W'(CS_GAP)) begin
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else begin
                  wait_q      <= wait_q + GAP_W'(1);
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready_o  = cmd_ready_q;
   assign busy_o       = busy_q;
   assign spi_en_o     = spi_en_q;
   assign spi_txbyte_o = spi_txbyte_q;
   assign rd_data_o    = rd_data_q;
   assign rd_valid_o   = rd_valid_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_ctrl
// Randomized bench for spi_flash_ctrl. A behavioural byte engine + flash model
// answers each frame from the opcode/address it actually receives; expected
// tx bytes and read data are built from the command alone.
// Honors SPI_FLASH_FAST_READ_EN.
// -----------------------------------------------------------------------------
module tb_spi_flash_ctrl;

   localparam int CS_GAP = 4;
`ifdef SPI_FLASH_FAST_READ_EN
   localparam int         RD_HDR = 5;
   localparam logic [7:0] RD_OPC = 8'h0B;
`else
   localparam int         RD_HDR = 4;
   localparam logic [7:0] RD_OPC = 8'h03;
`endif

   logic        sclk_i = 1'b0;
   logic        rst_n_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [1:0]  cmd_op_i;
   logic [23:0] cmd_addr_i;
   logic [8:0]  cmd_len_i;
   logic [7:0]  rd_data_o;
   logic        rd_valid_o;
   logic        done_o;
   logic        busy_o;
   logic        spi_en_o;
   logic [7:0]  spi_txbyte_o;
   logic        spi_flag_i;
   logic [7:0]  spi_rxbyte_i;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] txlog[$];   // bytes latched by the engine, in order
   logic [7:0] rdq[$];     // rd_data observed on rd_valid
   int         done_cnt;

   spi_flash_ctrl #(.CS_GAP(CS_GAP)) dut (
      .sclk_i       (sclk_i),
      .rst_n_i      (rst_n_i),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_op_i     (cmd_op_i),
      .cmd_addr_i   (cmd_addr_i),
      .cmd_len_i    (cmd_len_i),
      .rd_data_o    (rd_data_o),
      .rd_valid_o   (rd_valid_o),
      .done_o       (done_o),
      .busy_o       (busy_o),
      .spi_en_o     (spi_en_o),
      .spi_txbyte_o (spi_txbyte_o),
      .spi_flag_i   (spi_flag_i),
      .spi_rxbyte_i (spi_rxbyte_i)
   );

   always #5 sclk_i = ~sclk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Flash array contents: a ramp keyed on address (0x123456 -> 0xA0).
   function automatic logic [7:0] mem(input logic [23:0] a);
      return 8'(a - 24'h1233B6);
   endfunction

   function automatic logic [7:0] id_byte(input int i);
      case (i % 3)
         0:       return 8'hEF;
         1:       return 8'h40;
         default: return 8'h18;
      endcase
   endfunction

   // What the flash drives back during frame byte k, judged from the bytes
   // it has received. Header positions return junk.
   function automatic logic [7:0] flash_rx(input int k);
      logic [7:0] opc;
      int i;
      opc = txlog[0];
      if (opc == RD_OPC) begin
         if (k <= RD_HDR) return 8'($urandom);
         i = k - RD_HDR - 1;
         return mem({txlog[1], txlog[2], txlog[3]} + 24'(i));
      end
      if (k <= 1) return 8'($urandom);
      i = k - 2;
      case (opc)
         8'h9F:   return id_byte(i);
         8'h05:   return 8'h02;
         default: return 8'hFF;
      endcase
   endfunction

   // Byte engine: flag rises when a tx byte is latched, falls when that
   // byte's rx value is published; stops as soon as spi_en drops.
   initial begin : engine
      int  h, l, k;
      bit  alive;
      spi_flag_i   = 1'b0;
      spi_rxbyte_i = 8'h00;
      forever begin
         @(negedge sclk_i);
         if (spi_en_o === 1'b1) begin
            repeat ($urandom_range(1, 3)) @(negedge sclk_i);
            h = $urandom_range(2, 4);
            l = $urandom_range(1, 3);
            k = 0;
            alive = (spi_en_o === 1'b1);
            while (alive) begin
               k++;
               txlog.push_back(spi_txbyte_o);
               spi_flag_i = 1'b1;
               for (int i = 0; i < h && alive; i++) begin
                  @(negedge sclk_i);
                  alive = (spi_en_o === 1'b1);
               end
               if (alive) begin
                  spi_rxbyte_i = flash_rx(k);
                  spi_flag_i   = 1'b0;
                  for (int i = 0; i < l && alive; i++) begin
                     @(negedge sclk_i);
                     alive = (spi_en_o === 1'b1);
                  end
               end
            end
            spi_flag_i = 1'b0;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(posedge sclk_i);
         #1;
         if (rd_valid_o === 1'b1) rdq.push_back(rd_data_o);
         if (done_o === 1'b1) done_cnt++;
      end
   end

   task automatic wait_ready();
      int cyc = 0;
      while (cmd_ready_o !== 1'b1 && cyc < 2000) begin
         @(posedge sclk_i); #1; cyc++;
      end
      chk("ready_wait", cmd_ready_o, 1);
   endtask

   // Present one command, then scramble the inputs while busy.
   task automatic issue(input logic [1:0] op, input logic [23:0] addr, input logic [8:0] len);
      wait_ready();
      @(negedge sclk_i);
      txlog.delete();
      rdq.delete();
      done_cnt    = 0;
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_addr_i  = addr;
      cmd_len_i   = len;
      @(posedge sclk_i); #1;
      chk("acc_en", spi_en_o, 1);
      chk("acc_busy", busy_o, 1);
      chk("acc_ready", cmd_ready_o, 0);
      @(negedge sclk_i);
      cmd_op_i   = 2'($urandom);
      cmd_addr_i = 24'($urandom);
      cmd_len_i  = 9'($urandom);
      repeat (3) @(negedge sclk_i);
      cmd_valid_i = 1'b0;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [23:0] addr, input logic [8:0] len);
      logic [7:0] exp_tx[$];
      logic [7:0] exp_rd[$];
      int le, cyc, c;
      le = (len == 0) ? 1 : int'(len);
      case (op)
         2'd0: begin
            exp_tx.push_back(RD_OPC);
            exp_tx.push_back(addr[23:16]);
            exp_tx.push_back(addr[15:8]);
            exp_tx.push_back(addr[7:0]);
            if (RD_HDR == 5) exp_tx.push_back(8'h00);
         end
         2'd1:    exp_tx.push_back(8'h9F);
         2'd2:    exp_tx.push_back(8'h05);
         default: exp_tx.push_back(8'h06);
      endcase
      if (op != 2'd3) begin
         for (int i = 0; i < le; i++) begin
            exp_tx.push_back(8'h00);
            case (op)
               2'd0:    exp_rd.push_back(mem(addr + 24'(i)));
               2'd1:    exp_rd.push_back(id_byte(i));
               default: exp_rd.push_back(8'h02);
            endcase
         end
      end

      issue(op, addr, len);

      cyc = 0;
      while (done_o !== 1'b1 && cyc < 6000) begin
         @(posedge sclk_i); #1; cyc++;
      end
      chk("done_seen", done_o, 1);
      c = 0;
      while (cmd_ready_o !== 1'b1 && c < 100) begin
         @(posedge sclk_i); #1; c++;
         chk("gap_en_low", spi_en_o, 0);
      end
      chk("done_to_ready", c, CS_GAP + 1);
      chk("done_count", done_cnt, 1);
      chk("busy_end", busy_o, 0);
      chk("tx_count", txlog.size(), exp_tx.size() + 1);
      for (int i = 0; i < exp_tx.size(); i++)
         chk($sformatf("tx_byte%0d", i), (i < txlog.size()) ? txlog[i] : 8'hxx, exp_tx[i]);
      chk("rd_count", rdq.size(), exp_rd.size());
      for (int i = 0; i < exp_rd.size(); i++)
         chk($sformatf("rd_byte%0d", i), (i < rdq.size()) ? rdq[i] : 8'hxx, exp_rd[i]);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int cyc;
      rst_n_i     = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_op_i    = 2'd0;
      cmd_addr_i  = 24'd0;
      cmd_len_i   = 9'd0;
      done_cnt    = 0;

      // Reset values
      repeat (3) @(posedge sclk_i);
      #1;
      chk("rst_ready", cmd_ready_o, 0);
      chk("rst_en", spi_en_o, 0);
      chk("rst_txbyte", spi_txbyte_o, 8'h00);
      chk("rst_rddata", rd_data_o, 8'h00);
      chk("rst_rdvalid", rd_valid_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_busy", busy_o, 0);
      @(negedge sclk_i);
      rst_n_i = 1'b1;
      @(posedge sclk_i); #1;
      chk("post_rst_ready", cmd_ready_o, 1);

      // Directed cases
      run_cmd(2'd0, 24'h123456, 9'd4);
      run_cmd(2'd1, 24'h000000, 9'd3);
      run_cmd(2'd3, 24'hABCDEF, 9'd7);
      run_cmd(2'd0, 24'h00F000, 9'd0);
      run_cmd(2'd0, 24'h000010, 9'd2);

      // Reset during the third data byte of a READ len 8
      issue(2'd0, 24'h0A0B0C, 9'd8);
      cyc = 0;
      while (rdq.size() < 2 && cyc < 3000) begin
         @(posedge sclk_i); #1; cyc++;
      end
      chk("mid_rd_before_rst", rdq.size(), 2);
      @(negedge sclk_i);
      rst_n_i = 1'b0;
      @(posedge sclk_i); #1;
      chk("midrst_en", spi_en_o, 0);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_ready", cmd_ready_o, 0);
      chk("midrst_rdvalid", rd_valid_o, 0);
      repeat (2) @(posedge sclk_i);
      #1;
      chk("midrst_done_cnt", done_cnt, 0);
      chk("midrst_rd_cnt", rdq.size(), 2);
      @(negedge sclk_i);
      rst_n_i = 1'b1;
      run_cmd(2'd2, 24'h000000, 9'd1);

      // Randomized commands
      for (int n = 0; n < 20; n++) begin
         logic [1:0]  op;
         logic [23:0] addr;
         logic [8:0]  len;
         op   = 2'($urandom_range(0, 3));
         addr = 24'($urandom);
         len  = ($urandom_range(0, 9) == 0) ? 9'd256 : 9'($urandom_range(0, 10));
         run_cmd(op, addr, len);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
